// File: rtl/dpram_fifo_ctrl_if.sv
// Handshake and RAM-control bundle between the FIFO controller and its environment.
// The controller takes the slave modport; requesters, reader and DPRAM sit on the master side.
interface dpram_fifo_ctrl_if #(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 8
);
   logic                  wr0_valid;
   logic [DATA_WIDTH-1:0] wr0_data;
   logic                  wr0_ready;
   logic                  wr1_valid;
   logic [DATA_WIDTH-1:0] wr1_data;
   logic                  wr1_ready;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  empty;
   logic                  full;
   logic [ADDR_WIDTH:0]   level;
   logic                  afull;
   logic                  aempty;
   logic                  ram_we;
   logic [ADDR_WIDTH-1:0] ram_waddr;
   logic [DATA_WIDTH-1:0] ram_wdata;
   logic [ADDR_WIDTH-1:0] ram_raddr;
   logic [DATA_WIDTH-1:0] ram_rdata;

   modport slave (
      input  wr0_valid, wr0_data, wr1_valid, wr1_data, rd_en, ram_rdata,
      output wr0_ready, wr1_ready, rd_data, rd_valid, empty, full, level, afull, aempty,
             ram_we, ram_waddr, ram_wdata, ram_raddr
   );

   modport master (
      output wr0_valid, wr0_data, wr1_valid, wr1_data, rd_en, ram_rdata,
      input  wr0_ready, wr1_ready, rd_data, rd_valid, empty, full, level, afull, aempty,
             ram_we, ram_waddr, ram_wdata, ram_raddr
   );
endinterface

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller for one DPRAM: two round-robin writers on port A, one reader on port B.
// Define FIFO_ALMOST_FLAGS_EN for registered threshold-based almost-full/almost-empty flags.
module dpram_fifo_ctrl #(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned AF_THRESH  = 2,
   parameter int unsigned AE_THRESH  = 2
) (
   input  logic                clk_i,
   input  logic                rst_async_i,
   dpram_fifo_ctrl_if.slave    bus_io
);
   localparam int unsigned Depth = 2 ** ADDR_WIDTH;

   logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
   logic                last_gnt_q, last_gnt_d;
   logic                rd_valid_q;
   logic                empty, full;
   logic                gnt0, gnt1;
   logic                wr_acc, rd_acc;

   // Wrap bit distinguishes full from empty when the low bits coincide.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                  (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);

   always_comb begin
      gnt0       = bus_io.wr0_valid & (~bus_io.wr1_valid | last_gnt_q);
      gnt1       = bus_io.wr1_valid & (~bus_io.wr0_valid | ~last_gnt_q);
      wr_acc     = (gnt0 | gnt1) & ~full;
      rd_acc     = bus_io.rd_en & ~empty;
      last_gnt_d = wr_acc ? gnt1 : last_gnt_q;
      wr_ptr_d   = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, wr_acc};
      rd_ptr_d   = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, rd_acc};
   end

   always_ff @(posedge clk_i or posedge rst_async_i) begin
      if (rst_async_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         last_gnt_q <= 1'b1;
         rd_valid_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         last_gnt_q <= last_gnt_d;
         rd_valid_q <= rd_acc;
      end
   end

   assign bus_io.wr0_ready = gnt0 & ~full;
   assign bus_io.wr1_ready = gnt1 & ~full;
   assign bus_io.ram_we    = wr_acc;
   assign bus_io.ram_waddr = wr_ptr_q[ADDR_WIDTH-1:0];
   assign bus_io.ram_wdata = gnt1 ? bus_io.wr1_data : bus_io.wr0_data;
   assign bus_io.ram_raddr = rd_ptr_q[ADDR_WIDTH-1:0];
   assign bus_io.rd_data   = bus_io.ram_rdata;
   assign bus_io.rd_valid  = rd_valid_q;
   assign bus_io.empty     = empty;
   assign bus_io.full      = full;
   assign bus_io.level     = wr_ptr_q - rd_ptr_q;

`ifdef FIFO_ALMOST_FLAGS_EN
   logic                  afull_q, afull_d;
   logic                  aempty_q, aempty_d;
   logic [ADDR_WIDTH:0]   level_d;
   logic [ADDR_WIDTH+1:0] free_d;

   // Flags are computed from next-state level so they update alongside LEVEL.
   always_comb begin
      level_d  = wr_ptr_d - rd_ptr_d;
      free_d   = (ADDR_WIDTH + 2)'(Depth) - {1'b0, level_d};
      afull_d  = (free_d <= (ADDR_WIDTH + 2)'(AF_THRESH));
      aempty_d = ({1'b0, level_d} <= (ADDR_WIDTH + 2)'(AE_THRESH));
   end

   always_ff @(posedge clk_i or posedge rst_async_i) begin
      if (rst_async_i) begin
         afull_q  <= 1'b0;
         aempty_q <= 1'b1;
      end else begin
         afull_q  <= afull_d;
         aempty_q <= aempty_d;
      end
   end

   assign bus_io.afull  = afull_q;
   assign bus_io.aempty = aempty_q;
`else
   assign bus_io.afull  = full;
   assign bus_io.aempty = empty;
`endif
endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Randomised scoreboard bench for dpram_fifo_ctrl with a behavioural DPRAM beside it.
module tb_dpram_fifo_ctrl;
   localparam int unsigned AW    = 4;
   localparam int unsigned DW    = 8;
   localparam int unsigned Depth = 16;
   localparam int unsigned AFT   = 2;
   localparam int unsigned AET   = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dpram_fifo_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   dpram_fifo_ctrl #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .AF_THRESH (AFT),
      .AE_THRESH (AET)
   ) dut (
      .clk_i      (clk),
      .rst_async_i(rst),
      .bus_io     (bus)
   );

   // DPRAM: port A write, registered port B read.
   logic [DW-1:0] mem [Depth];
   always @(posedge clk) begin
      if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_wdata;
      bus.ram_rdata <= mem[bus.ram_raddr];
   end

   int n_cmp = 0;
   int n_bad = 0;

   logic [DW-1:0] model_q [$];   // words held by the FIFO
   logic [DW-1:0] exp_q   [$];   // popped words awaiting RD_VALID
   bit            m_last  = 1'b1;
   bit            m_rv    = 1'b0;
   bit            pend0   = 1'b0;
   bit            pend1   = 1'b0;
   logic [DW-1:0] dat0    = '0;
   logic [DW-1:0] dat1    = '0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_state();
      int cnt;
      cnt = model_q.size();
      check("level", 32'(bus.level), 32'(cnt));
      check("empty", 32'(bus.empty), 32'(cnt == 0));
      check("full", 32'(bus.full), 32'(cnt == Depth));
      check("rd_valid", 32'(bus.rd_valid), 32'(m_rv));
`ifdef FIFO_ALMOST_FLAGS_EN
      check("afull", 32'(bus.afull), 32'((Depth - cnt) <= AFT));
      check("aempty", 32'(bus.aempty), 32'(cnt <= AET));
`else
      check("afull", 32'(bus.afull), 32'(cnt == Depth));
      check("aempty", 32'(bus.aempty), 32'(cnt == 0));
`endif
   endtask

   // Predict this cycle's handshakes, then commit them to the model as of the next edge.
   task automatic cycle_check();
      int cnt;
      bit g0, g1, acc, pop;
      cnt = model_q.size();
      check_state();
      g0  = pend0 && (!pend1 || m_last);
      g1  = pend1 && (!pend0 || !m_last);
      acc = (g0 || g1) && (cnt < Depth);
      pop = bus.rd_en && (cnt > 0);
      check("wr0_ready", 32'(bus.wr0_ready), 32'(g0 && cnt < Depth));
      check("wr1_ready", 32'(bus.wr1_ready), 32'(g1 && cnt < Depth));
      check("ram_we", 32'(bus.ram_we), 32'(acc));
      if (pop) exp_q.push_back(model_q.pop_front());
      if (acc) begin
         model_q.push_back(g1 ? dat1 : dat0);
         m_last = g1;
         if (g1) pend1 = 1'b0;
         else    pend0 = 1'b0;
      end
      m_rv = pop;
   endtask

   task automatic run(input int n, input int unsigned wp, input int unsigned rp, input int rst_at);
      for (int c = 0; c < n; c++) begin
         @(posedge clk);
         #1;
         if (c == rst_at) begin
            rst = 1'b1;
            #1;
            check("rst_empty", 32'(bus.empty), 32'd1);
            check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
            check("rst_level", 32'(bus.level), 32'd0);
            rst = 1'b0;
            model_q.delete();
            exp_q.delete();
            m_last = 1'b1;
            m_rv   = 1'b0;
            pend0  = 1'b0;
            pend1  = 1'b0;
         end
         if (!pend0 && $urandom_range(99) < wp) begin
            pend0 = 1'b1;
            dat0  = DW'($urandom_range(255));
         end
         if (!pend1 && $urandom_range(99) < wp) begin
            pend1 = 1'b1;
            dat1  = DW'($urandom_range(255));
         end
         bus.wr0_valid = pend0;
         bus.wr0_data  = dat0;
         bus.wr1_valid = pend1;
         bus.wr1_data  = dat1;
         bus.rd_en     = ($urandom_range(99) < rp);
         @(negedge clk);
         cycle_check();
      end
   endtask

   // Monitor: every presented word must be the oldest outstanding pop.
   initial begin
      logic [DW-1:0] e;
      forever begin
         @(negedge clk);
         if (bus.rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("rd_unexpected", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("rd_data", 32'(bus.rd_data), 32'(e));
            end
         end
      end
   end

   initial begin
      bus.wr0_valid = 1'b0;
      bus.wr0_data  = '0;
      bus.wr1_valid = 1'b0;
      bus.wr1_data  = '0;
      bus.rd_en     = 1'b0;
      repeat (2) @(negedge clk);
      check_state();
      rst = 1'b0;

      run(40, 100, 0, -1);    // both requesters hammer until full
      run(6, 100, 100, -1);   // full with reads: pop frees one slot per cycle
      run(40, 0, 100, -1);    // drain and keep popping while empty
      run(20, 50, 100, -1);   // writes landing into an empty FIFO under RD_EN
      run(300, 60, 55, 150);  // mixed traffic with an async reset mid-stream
      run(100, 90, 20, -1);   // linger near full
      run(40, 0, 100, -1);
      repeat (3) @(negedge clk);
      check("exp_q_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
